// File: rtl/bit_order_serdes.sv
// Parallel-to-serial / serial-to-parallel converter with a load-time bit order select.
// The transmit and receive halves run in lock-step: every bit sent has one bit received at the same index.
module bit_order_serdes #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] tx_reg, tx_next;
  logic [WIDTH-1:0] rx_reg, rx_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CW-1:0]    rx_idx;
  logic             mode_reg, mode_next;
  logic             ser_out_reg, ser_out_next;
  logic             ser_valid_reg, ser_valid_next;
  logic             out_valid_reg, out_valid_next;
  logic             busy_reg, busy_next;
  logic             load_fire;

  assign load_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign load_fire  = load_valid && load_ready;

  // Received bit lands at the same index that is on the wire this cycle.
  assign rx_idx = mode_reg ? (LAST - cnt_reg) : cnt_reg;

  assign ser_out   = ser_out_reg;
  assign ser_valid = ser_valid_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = rx_reg;
  assign busy      = busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      tx_reg        <= '0;
      rx_reg        <= '0;
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      ser_out_reg   <= 1'b0;
      ser_valid_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      cnt_reg       <= cnt_next;
      mode_reg      <= mode_next;
      ser_out_reg   <= ser_out_next;
      ser_valid_reg <= ser_valid_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    cnt_next       = cnt_reg;
    mode_next      = mode_reg;
    ser_out_next   = ser_out_reg;
    ser_valid_next = ser_valid_reg;
    out_valid_next = out_valid_reg;
    busy_next      = busy_reg;

    case (state_reg)
      SHIFT: begin
        rx_next[rx_idx] = ser_in;
        if (cnt_reg == LAST) begin
          state_next     = DONE;
          ser_out_next   = 1'b0;
          ser_valid_next = 1'b0;
          out_valid_next = 1'b1;
        end else begin
          cnt_next     = cnt_reg + 1'b1;
          ser_out_next = mode_reg ? tx_reg[WIDTH-1] : tx_reg[0];
          tx_next      = mode_reg ? (tx_reg << 1) : (tx_reg >> 1);
        end
      end
      DONE: begin
        if (out_ready && !load_valid) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
          busy_next      = 1'b0;
        end
      end
      default: ;
    endcase

    // The first bit goes straight to the output flop; the shift register keeps the rest.
    if (load_fire) begin
      state_next     = SHIFT;
      mode_next      = msb_first;
      ser_out_next   = msb_first ? load_data[WIDTH-1] : load_data[0];
      tx_next        = msb_first ? (load_data << 1) : (load_data >> 1);
      cnt_next       = '0;
      rx_next        = '0;
      ser_valid_next = 1'b1;
      out_valid_next = 1'b0;
      busy_next      = 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_order_serdes.sv
// Randomized and directed bench for bit_order_serdes at WIDTH=8 and WIDTH=16.
// Expected wire order and received words come from index arithmetic on the loaded word.
module tb_bit_order_serdes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_valid, sel16, msb_first, out_ready, drv_bit, loop_en;
  logic [15:0] load_data;

  logic       load_ready8, ser_out8, ser_valid8, ser_in8, out_valid8, busy8;
  logic [7:0] out_data8;
  logic       load_ready16, ser_out16, ser_valid16, ser_in16, out_valid16, busy16;
  logic [15:0] out_data16;

  logic        m_ser_out, m_ser_valid, m_out_valid, m_busy, m_load_ready;
  logic [15:0] m_out_data;

  int checks = 0;
  int errors = 0;

  assign ser_in8  = loop_en ? ser_out8  : drv_bit;
  assign ser_in16 = loop_en ? ser_out16 : drv_bit;

  assign m_ser_out    = sel16 ? ser_out16    : ser_out8;
  assign m_ser_valid  = sel16 ? ser_valid16  : ser_valid8;
  assign m_out_valid  = sel16 ? out_valid16  : out_valid8;
  assign m_busy       = sel16 ? busy16       : busy8;
  assign m_load_ready = sel16 ? load_ready16 : load_ready8;
  assign m_out_data   = sel16 ? out_data16   : {8'h00, out_data8};

  bit_order_serdes #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .load_valid(load_valid && !sel16), .load_ready(load_ready8),
    .load_data(load_data[7:0]), .msb_first(msb_first),
    .ser_out(ser_out8), .ser_valid(ser_valid8), .ser_in(ser_in8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .busy(busy8)
  );

  bit_order_serdes #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .load_valid(load_valid && sel16), .load_ready(load_ready16),
    .load_data(load_data), .msb_first(msb_first),
    .ser_out(ser_out16), .ser_valid(ser_valid16), .ser_in(ser_in16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_load_ready8"}, load_ready8, 1'b1);
    check({tag, "_ser_out8"}, ser_out8, 1'b0);
    check({tag, "_ser_valid8"}, ser_valid8, 1'b0);
    check({tag, "_out_valid8"}, out_valid8, 1'b0);
    check({tag, "_out_data8"}, out_data8, 8'h00);
    check({tag, "_busy8"}, busy8, 1'b0);
    check({tag, "_load_ready16"}, load_ready16, 1'b1);
    check({tag, "_ser_valid16"}, ser_valid16, 1'b0);
    check({tag, "_out_data16"}, out_data16, 16'h0000);
    check({tag, "_busy16"}, busy16, 1'b0);
  endtask

  // Called at a falling edge; returns at the falling edge of the first bit cycle.
  task automatic start_load(input logic [15:0] word, input logic mode);
    load_valid = 1'b1;
    load_data  = word;
    msb_first  = mode;
    #1 check("load_ready_at_load", m_load_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'($urandom);
  endtask

  // Walks the frame bit by bit and ends at the falling edge of the DONE cycle.
  task automatic shift_frame(input int w, input logic [15:0] word, input logic mode,
                             input logic loop, input logic [15:0] rbits,
                             input logic toggle, input logic poke,
                             output logic [15:0] exp_out);
    int idx;
    logic eb;
    exp_out = '0;
    for (int k = 0; k < w; k++) begin
      idx = mode ? (w - 1 - k) : k;
      eb  = word[idx];
      check("ser_valid", m_ser_valid, 1'b1);
      check("ser_out", m_ser_out, eb);
      if (k == 0) begin
        check("busy_shift", m_busy, 1'b1);
        check("load_ready_shift", m_load_ready, 1'b0);
        check("out_valid_shift", m_out_valid, 1'b0);
      end
      loop_en = loop;
      drv_bit = rbits[k];
      exp_out[idx] = loop ? eb : rbits[k];
      if (toggle && k == w / 2) msb_first = ~msb_first;
      if (poke && k == 2) begin
        load_valid = 1'b1;
        load_data  = 16'($urandom);
      end
      if (poke && k == 3) load_valid = 1'b0;
      @(negedge clk);
    end
    check("ser_valid_done", m_ser_valid, 1'b0);
    check("out_valid_done", m_out_valid, 1'b1);
    check("busy_done", m_busy, 1'b1);
    check("out_data", m_out_data, exp_out);
    $display("frame w=%0d word=%h msb=%0b loop=%0b out=%h", w, word, mode, loop, m_out_data);
  endtask

  initial begin
    logic [15:0] res, word;
    logic        mode, seen;
    int          w;

    rst = 1'b1; load_valid = 1'b0; sel16 = 1'b0; msb_first = 1'b0;
    out_ready = 1'b1; drv_bit = 1'b0; loop_en = 1'b0; load_data = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // MSB-first single set bit, receive line held low.
    start_load(16'h0001, 1'b1);
    shift_frame(8, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, res);
    @(negedge clk);

    // LSB-first, looped back.
    start_load(16'h0001, 1'b0);
    shift_frame(8, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, res);
    check("lsb_loop_word", res, 16'h0001);
    @(negedge clk);

    // Loopback with msb_first toggled mid-frame and an ignored load attempt.
    start_load(16'h00A5, 1'b1);
    shift_frame(8, 16'h00A5, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, res);
    check("loop_a5", res, 16'h00A5);
    @(negedge clk);
    start_load(16'h003C, 1'b0);
    shift_frame(8, 16'h003C, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, res);
    check("loop_3c", res, 16'h003C);
    @(negedge clk);

    // Back-pressure for 5 DONE cycles, then a back-to-back load.
    out_ready = 1'b0;
    start_load(16'h005A, 1'b1);
    shift_frame(8, 16'h005A, 1'b1, 1'b0, 16'h00C3, 1'b0, 1'b0, res);
    check("bp_load_ready", m_load_ready, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_out_valid", m_out_valid, 1'b1);
      check("bp_out_data", m_out_data, res);
    end
    out_ready = 1'b1;
    start_load(16'h0096, 1'b0);
    shift_frame(8, 16'h0096, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, res);
    check("b2b_word", res, 16'h0096);
    @(negedge clk);
    check("idle_after_done", m_busy, 1'b0);

    // Reset held for 2 cycles while idle.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("idle_reset");
    rst = 1'b0;
    @(negedge clk);

    // Mid-frame asynchronous reset on the 16-bit instance at bit 5.
    sel16 = 1'b1;
    start_load(16'hBEEF, 1'b1);
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy16, 1'b0);
    check("mid_rst_ser_valid", ser_valid16, 1'b0);
    check("mid_rst_out_data", out_data16, 16'h0000);
    check("mid_rst_load_ready", load_ready16, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid16) seen = 1'b1;
    end
    check("mid_rst_no_out_valid", seen, 1'b0);
    start_load(16'h1234, 1'b0);
    shift_frame(16, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, res);
    check("post_rst_word", res, 16'h1234);
    @(negedge clk);

    // Randomized frames on both widths.
    for (int i = 0; i < 40; i++) begin
      sel16 = 1'($urandom);
      w     = sel16 ? 16 : 8;
      word  = sel16 ? 16'($urandom) : {8'h00, 8'($urandom)};
      mode  = 1'($urandom);
      start_load(word, mode);
      shift_frame(w, word, mode, 1'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), res);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
